// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result queues (ALU1, ALU2, LSB) drained
// one entry per cycle onto a registered broadcast bus in round-robin order.
// Latency: a result accepted at edge N appears on the bus after edge N+1 at the earliest.
// Backpressure: stall_* rises combinationally when a queue is full; the producer holds its result.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global pause), clear_signal (flush)
//   done_/value_/tag_{alu_1,alu_2,lsb} : producer result strobes, data and ROB tags
//   stall_{alu_1,alu_2,lsb}            : queue-full indications back to the producers
//   cdb_valid/cdb_value/cdb_tag/cdb_src: registered broadcast (src 0=ALU1, 1=ALU2, 2=LSB)

// Small circular queue used once per source. Push/pop/clear arrive fully
// qualified from the parent, so this block only tracks storage and occupancy.
module cdb_fifo #(
  parameter int DW = 36,
  parameter int AW = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdat_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdat_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_WIDTH = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 done_alu_1,
  input  logic                 done_alu_2,
  input  logic                 done_lsb,
  input  logic [31:0]          value_alu_1,
  input  logic [31:0]          value_alu_2,
  input  logic [31:0]          value_lsb,
  input  logic [ROB_WIDTH-1:0] tag_alu_1,
  input  logic [ROB_WIDTH-1:0] tag_alu_2,
  input  logic [ROB_WIDTH-1:0] tag_lsb,
  output logic                 stall_alu_1,
  output logic                 stall_alu_2,
  output logic                 stall_lsb,
  output logic                 cdb_valid,
  output logic [31:0]          cdb_value,
  output logic [ROB_WIDTH-1:0] cdb_tag,
  output logic [1:0]           cdb_src
);
  localparam int DW = 32 + ROB_WIDTH;

  logic [2:0]    done_v, full_v, empty_v, push_v, pop_v;
  logic [DW-1:0] wdat [3];
  logic [DW-1:0] head [3];
  logic          clr;

  logic                 grant_vld;
  logic [1:0]           grant_idx;
  logic [DW-1:0]        grant_dat;

  logic                 valid_q, valid_d;
  logic [31:0]          value_q, value_d;
  logic [ROB_WIDTH-1:0] tag_q, tag_d;
  logic [1:0]           src_q, src_d, rr_q, rr_d;

  // Modulo-3 add for the round-robin pointer (operands are always 0..2).
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign done_v  = {done_lsb, done_alu_2, done_alu_1};
  assign wdat[0] = {value_alu_1, tag_alu_1};
  assign wdat[1] = {value_alu_2, tag_alu_2};
  assign wdat[2] = {value_lsb,   tag_lsb};

  assign clr = rdy_in & clear_signal;

  for (genvar g = 0; g < 3; g++) begin : g_src
    // Accept only when the queue was not full before this edge, so a full queue is never written.
    assign push_v[g] = rdy_in & ~clear_signal & done_v[g] & ~full_v[g];
    assign pop_v[g]  = rdy_in & ~clear_signal & grant_vld & (grant_idx == 2'(g));

    cdb_fifo #(.DW(DW), .AW(FIFO_WIDTH)) u_fifo (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .clr_i   (clr),
      .push_i  (push_v[g]),
      .pop_i   (pop_v[g]),
      .wdat_i  (wdat[g]),
      .head_o  (head[g]),
      .full_o  (full_v[g]),
      .empty_o (empty_v[g])
    );
  end

  // Counts clear asynchronously, but gate explicitly so stalls read 0 throughout reset.
  assign stall_alu_1 = full_v[0] & ~rst_in;
  assign stall_alu_2 = full_v[1] & ~rst_in;
  assign stall_lsb   = full_v[2] & ~rst_in;

  // Round-robin search from rr_q using occupancy as it stood before the edge.
  always_comb begin
    logic [1:0] idx;
    grant_vld = 1'b0;
    grant_idx = rr_q;
    idx       = rr_q;
    for (int i = 0; i < 3; i++) begin
      idx = rr_add(rr_q, 2'(i));
      if (!grant_vld && !empty_v[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_dat = head[0];
      2'd1:    grant_dat = head[1];
      default: grant_dat = head[2];
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    tag_d   = tag_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (clear_signal) begin
      valid_d = 1'b0;
      rr_d    = 2'd0;
    end else if (grant_vld) begin
      valid_d = 1'b1;
      value_d = grant_dat[DW-1 -: 32];
      tag_d   = grant_dat[ROB_WIDTH-1:0];
      src_d   = grant_idx;
      rr_d    = rr_add(grant_idx, 2'd1);
    end else begin
      valid_d = 1'b0;
    end
  end

  // rdy_in low freezes every register, including the broadcast bus.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      value_q <= '0;
      tag_q   <= '0;
      src_q   <= '0;
      rr_q    <= '0;
    end else if (rdy_in) begin
      valid_q <= valid_d;
      value_q <= value_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_value = value_q;
  assign cdb_tag   = tag_q;
  assign cdb_src   = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed stimulus, scoreboard of expected broadcasts
// drained by a negedge monitor, plus direct checks of stalls, latency and reset.
module tb_cdb_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal;
  logic        done_alu_1, done_alu_2, done_lsb;
  logic [31:0] value_alu_1, value_alu_2, value_lsb;
  logic [3:0]  tag_alu_1, tag_alu_2, tag_lsb;
  logic        stall_alu_1, stall_alu_2, stall_lsb;
  logic        cdb_valid;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_tag;
  logic [1:0]  cdb_src;

  cdb_arbiter #(.ROB_WIDTH(4), .FIFO_WIDTH(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .done_alu_1(done_alu_1), .done_alu_2(done_alu_2), .done_lsb(done_lsb),
    .value_alu_1(value_alu_1), .value_alu_2(value_alu_2), .value_lsb(value_lsb),
    .tag_alu_1(tag_alu_1), .tag_alu_2(tag_alu_2), .tag_lsb(tag_lsb),
    .stall_alu_1(stall_alu_1), .stall_alu_2(stall_alu_2), .stall_lsb(stall_lsb),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] v;
    logic [3:0]  t;
    logic [1:0]  s;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic edge_live = 1'b0;

  function automatic logic [31:0] vf(input int s, input logic [3:0] t);
    return 32'hC0DE_0000 + 32'(s * 256) + 32'(t);
  endfunction

  task automatic exp_bc(input logic [31:0] v, input logic [3:0] t, input logic [1:0] s);
    exp_t e;
    e.v = v; e.t = t; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // d[0]=ALU1, d[1]=ALU2, d[2]=LSB; values derived from source and tag.
  task automatic drv(input logic [2:0] d, input logic [3:0] t1, input logic [3:0] t2, input logic [3:0] tl);
    done_alu_1 = d[0]; tag_alu_1 = t1; value_alu_1 = vf(0, t1);
    done_alu_2 = d[1]; tag_alu_2 = t2; value_alu_2 = vf(1, t2);
    done_lsb   = d[2]; tag_lsb   = tl; value_lsb   = vf(2, tl);
  endtask

  // A broadcast is new only if the preceding edge was not paused.
  always @(posedge clk_in) edge_live <= rdy_in;

  always @(negedge clk_in) begin
    if (!rst_in && edge_live && cdb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bc: got tag=%0d src=%0d value=%h, expected no broadcast",
                 cdb_tag, cdb_src, cdb_value);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cdb_value !== e.v || cdb_tag !== e.t || cdb_src !== e.s) begin
          failures++;
          $display("FAIL bc: got tag=%0d src=%0d value=%h, expected tag=%0d src=%0d value=%h",
                   cdb_tag, cdb_src, cdb_value, e.t, e.s, e.v);
        end
      end
    end
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0;
    drv(3'b000, 0, 0, 0);
    #12;
    chk("rst_valid", 32'(cdb_valid), 0);
    chk("rst_value", cdb_value, 0);
    chk("rst_tag", 32'(cdb_tag), 0);
    chk("rst_src", 32'(cdb_src), 0);
    chk("rst_stalls", {29'd0, stall_lsb, stall_alu_2, stall_alu_1}, 0);
    rst_in = 1'b0;
    step();

    // Three-way contention from reset: ALU1, ALU2, LSB in order.
    drv(3'b111, 1, 2, 3);
    exp_bc(vf(0, 1), 1, 0); exp_bc(vf(1, 2), 2, 1); exp_bc(vf(2, 3), 3, 2);
    step(); drv(3'b000, 0, 0, 0);
    step(5);

    // Single result with minimum latency.
    drv(3'b010, 0, 5, 0); value_alu_2 = 32'h0000_00AA;
    exp_bc(32'h0000_00AA, 5, 1);
    step(); drv(3'b000, 0, 0, 0);
    chk("lat_edge1_valid", 32'(cdb_valid), 0);
    step();
    chk("lat_edge2_valid", 32'(cdb_valid), 1);
    chk("lat_edge2_src", 32'(cdb_src), 1);
    step();
    chk("lat_edge3_valid", 32'(cdb_valid), 0);
    step(3);

    // Backpressure: LSB fills while ALU queues hold the grant, held tag 10 accepted after a pop.
    rst_in = 1'b1; #2; rst_in = 1'b0;
    exp_bc(vf(0, 1), 1, 0); exp_bc(vf(1, 2), 2, 1); exp_bc(vf(2, 8), 8, 2);
    exp_bc(vf(0, 3), 3, 0); exp_bc(vf(1, 4), 4, 1); exp_bc(vf(2, 9), 9, 2);
    exp_bc(vf(2, 10), 10, 2);
    drv(3'b111, 1, 2, 8);  step();
    drv(3'b111, 3, 4, 9);  step();
    chk("bp_stall_lsb_full", 32'(stall_lsb), 1);
    chk("bp_stall_alu2_full", 32'(stall_alu_2), 1);
    chk("bp_stall_alu1", 32'(stall_alu_1), 0);
    drv(3'b100, 0, 0, 10); step();
    chk("bp_stall_lsb_hold", 32'(stall_lsb), 1);
    step();
    chk("bp_stall_lsb_popped", 32'(stall_lsb), 0);
    step();
    chk("bp_stall_lsb_refill", 32'(stall_lsb), 1);
    drv(3'b000, 0, 0, 0);
    step(6);

    // Flush with a same-cycle ALU1 result that must be ignored.
    drv(3'b111, 1, 2, 3); step();
    drv(3'b111, 4, 5, 6); exp_bc(vf(0, 1), 1, 0); step();
    chk("fl_pre_stall_alu2", 32'(stall_alu_2), 1);
    clear_signal = 1'b1; drv(3'b001, 7, 0, 0); step();
    clear_signal = 1'b0; drv(3'b000, 0, 0, 0);
    chk("fl_valid", 32'(cdb_valid), 0);
    chk("fl_stalls", {29'd0, stall_lsb, stall_alu_2, stall_alu_1}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_idle_valid", 32'(cdb_valid), 0);
    end

    // Pause while a broadcast is on the bus; done and clear are ignored meanwhile.
    drv(3'b110, 0, 6, 7); step();
    drv(3'b000, 0, 0, 0);
    exp_bc(vf(1, 6), 6, 1); exp_bc(vf(2, 7), 7, 2);
    step();
    rdy_in = 1'b0; clear_signal = 1'b1; drv(3'b001, 15, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_valid", 32'(cdb_valid), 1);
      chk("pause_tag", 32'(cdb_tag), 6);
    end
    rdy_in = 1'b1; clear_signal = 1'b0; drv(3'b000, 0, 0, 0);
    step();
    chk("resume_tag", 32'(cdb_tag), 7);
    step(3);

    // Mid-cycle reset discards the queued LSB entry and returns rr to ALU1.
    drv(3'b110, 0, 11, 12); step();
    drv(3'b000, 0, 0, 0); exp_bc(vf(1, 11), 11, 1);
    step();
    @(negedge clk_in); #1;
    rst_in = 1'b1; #1;
    chk("arst_valid", 32'(cdb_valid), 0);
    chk("arst_value", cdb_value, 0);
    chk("arst_stalls", {29'd0, stall_lsb, stall_alu_2, stall_alu_1}, 0);
    #1 rst_in = 1'b0;
    drv(3'b101, 14, 0, 13);
    exp_bc(vf(0, 14), 14, 0); exp_bc(vf(2, 13), 13, 2);
    step(); drv(3'b000, 0, 0, 0);
    step(4);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
